// File: rtl/alu_pkg.sv
// Shared types for the 4-bit ALU block.
// Opcode enum is imported by the DUT and its bench.
package alu_pkg;

  typedef enum logic [1:0] {
    Add           = 2'b00,
    Sub           = 2'b01,
    Not_A         = 2'b10,
    ReductionOR_B = 2'b11
  } opcode_e;

  localparam int unsigned OpW  = 4;
  localparam int unsigned ResW = OpW + 1;

endpackage

// File: rtl/alu_4_bit_core.sv
// Combinational ALU datapath: opcode, A, B -> next 5-bit result.
// Operands are sign-extended to 5 bits before any arithmetic.
module alu_4_bit_core
  import alu_pkg::*;
(
  input  opcode_e                  opcode,
  input  logic signed [OpW-1:0]    A,
  input  logic signed [OpW-1:0]    B,
  output logic signed [ResW-1:0]   result
);

  logic signed [ResW-1:0] a_ext;
  logic signed [ResW-1:0] b_ext;
  logic                   b_any;

  assign a_ext = {A[OpW-1], A};
  assign b_ext = {B[OpW-1], B};
  assign b_any = |B;

  always_comb begin
    result = '0;
    unique case (opcode)
      Add:           result = a_ext + b_ext;
      Sub:           result = a_ext - b_ext;
      Not_A:         result = ~a_ext;
      ReductionOR_B: result = {{(ResW-1){1'b0}}, b_any};
      default:       result = '0;
    endcase
  end

endmodule

// File: rtl/alu_4_bit.sv
// 4-bit signed ALU with a registered 5-bit result.
// Reset is asynchronous, active-low, and clears the result at once.
module alu_4_bit
  import alu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  opcode_e                 opcode,
  input  logic signed [OpW-1:0]   A,
  input  logic signed [OpW-1:0]   B,
  output logic signed [ResW-1:0]  C
);

  logic signed [ResW-1:0] next_c;

  alu_4_bit_core u_core (
    .opcode (opcode),
    .A      (A),
    .B      (B),
    .result (next_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      C <= '0;
    end else begin
      C <= next_c;
    end
  end

endmodule

// File: tb/tb_alu_4_bit.sv
// Self-checking bench for alu_4_bit.
// Expected results are queued on drive and popped when C is sampled.
module tb_alu_4_bit;
  import alu_pkg::*;

  logic              clk;
  logic              reset;
  opcode_e           opcode;
  logic signed [3:0] A;
  logic signed [3:0] B;
  logic signed [4:0] C;

  int checks;
  int fails;

  logic [4:0] exp_q[$];

  alu_4_bit dut (
    .clk    (clk),
    .reset  (reset),
    .opcode (opcode),
    .A      (A),
    .B      (B),
    .C      (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] model(
    input opcode_e op,
    input int      a,
    input int      b
  );
    int r;
    case (op)
      Add:           r = a + b;
      Sub:           r = a - b;
      Not_A:         r = -a - 1;
      ReductionOR_B: r = (b != 0) ? 1 : 0;
      default:       r = 0;
    endcase
    return r[4:0];
  endfunction

  function automatic int sx4(input logic [3:0] v);
    int r;
    r = int'(v);
    if (v[3]) r = r - 16;
    return r;
  endfunction

  task automatic pop_check(input string name);
    logic [4:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, C=%0d", name, C);
    end else begin
      exp = exp_q.pop_front();
      if (C !== exp) begin
        fails++;
        $display("FAIL %s: C=%0d (%b) expected %0d (%b)",
                 name, C, C, $signed(exp), exp);
      end
    end
  endtask

  task automatic run_op(
    input opcode_e op,
    input int      a,
    input int      b,
    input string   name
  );
    logic [31:0] av;
    logic [31:0] bv;
    av = a;
    bv = b;
    @(negedge clk);
    opcode = op;
    A = av[3:0];
    B = bv[3:0];
    exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    pop_check(name);
  endtask

  task automatic test_reset();
    @(negedge clk);
    exp_q.push_back(5'd0);
    pop_check("reset_initial");
    reset = 1'b1;
    run_op(Add, 1, 1, "pre_reset_load");
    @(negedge clk);
    opcode = Add;
    A = 4'sd7;
    B = 4'sd7;
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(5'd0);
    pop_check("reset_immediate");
    @(posedge clk);
    #1;
    exp_q.push_back(5'd0);
    pop_check("reset_held_over_edge");
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(model(Add, 7, 7));
    @(posedge clk);
    #1;
    pop_check("reset_release_first_edge");
  endtask

  task automatic test_add();
    run_op(Add, -8, -8, "add_min_min");
    run_op(Add, 7, -8, "add_7_m8");
    run_op(Add, 7, 7, "add_7_7");
    run_op(Add, -3, 2, "add_m3_2");
  endtask

  task automatic test_sub();
    run_op(Sub, -8, 7, "sub_m8_7");
    run_op(Sub, 7, -8, "sub_7_m8");
    run_op(Sub, 0, 0, "sub_0_0");
  endtask

  task automatic test_not_a();
    run_op(Not_A, 5, 0, "not_5");
    run_op(Not_A, -1, 3, "not_m1");
    run_op(Not_A, -8, -8, "not_m8");
  endtask

  task automatic test_red_or();
    run_op(ReductionOR_B, 7, 0, "ror_b0");
    run_op(ReductionOR_B, 7, -8, "ror_bm8_a7");
    run_op(ReductionOR_B, -8, -8, "ror_bm8_am8");
    run_op(ReductionOR_B, -8, 0, "ror_b0_am8");
  endtask

  task automatic test_hold();
    run_op(Sub, 3, -4, "hold_load");
    #1;
    opcode = Add;
    A = -4'sd8;
    B = -4'sd8;
    @(negedge clk);
    exp_q.push_back(model(Sub, 3, -4));
    pop_check("hold_between_edges");
  endtask

  task automatic test_back_to_back();
    int n;
    int a;
    int b;
    logic rst_v;
    opcode_e op;
    n = 20000;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = $urandom_range(0, 15) - 8;
      b = $urandom_range(0, 15) - 8;
      op = opcode_e'($urandom_range(0, 3));
      rst_v = ($urandom_range(0, 15) != 0);
      opcode = op;
      A = a[3:0];
      B = b[3:0];
      reset = rst_v;
      exp_q.push_back(rst_v ? model(op, sx4(A), sx4(B)) : 5'd0);
      @(negedge clk);
      pop_check("random");
    end
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    fails = 0;
    reset = 1'b0;
    opcode = Add;
    A = 4'sd0;
    B = 4'sd0;
    test_reset();
    test_add();
    test_sub();
    test_not_a();
    test_red_or();
    test_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
